// File: rtl/reindeer_mem_responder.sv
// reindeer_mem_responder
//   Memory-side responder for the core's unified memory port. It owns the
//   on-chip word RAM and services byte-lane writes and 1-cycle-latency reads.
//   After every reset it zero-fills the RAM, then raises init_done. Accesses
//   beyond DEPTH are dropped and flagged on a sticky addr_err.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   sync_reset     synchronous restart of the clear sequence
//   mem_addr       word address of the request
//   mem_read_en    read request this cycle
//   mem_write_en   per-byte write strobes
//   mem_write_data write data
//   mem_read_data  registered read data
//   init_done      RAM cleared, requests accepted
//   addr_err       sticky out-of-range access flag
//   err_clear      clears the sticky error flags
//   parity_err     (MEM_PARITY_EN only) sticky read parity error flag
//
// Configuration
//   MEM_PARITY_EN  when defined, one even-parity bit is stored per byte lane
//                  and checked on every accepted read.
module reindeer_mem_responder #(
    parameter int ADDR_BITS = 14,
    parameter int XLEN      = 32,
    parameter int DEPTH     = 12288
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic [ADDR_BITS-1:0]  mem_addr,
    input  logic                  mem_read_en,
    input  logic [XLEN/8-1:0]     mem_write_en,
    input  logic [XLEN-1:0]       mem_write_data,
    output logic [XLEN-1:0]       mem_read_data,
    output logic                  init_done,
    output logic                  addr_err,
    input  logic                  err_clear
`ifdef MEM_PARITY_EN
    ,
    output logic                  parity_err
`endif
);

    localparam int LANES = XLEN / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            addr_err_q, addr_err_d;
    logic            rd_zero_q, rd_zero_d;   // output forced to 0 (reset / out-of-range read)

    logic            clearing;
    logic            last_word;
    logic [31:0]     addr_ext;
    logic            in_range;
    logic            req_ok;
    logic            rd_accept;
    logic            wr_accept;
    logic            err_event;

    logic [AW-1:0]                  ram_addr;
    logic [LANES-1:0]               ram_we;
    logic [LANES-1:0][LANE_W-1:0]   ram_wdata;
    logic [LANES-1:0][LANE_W-1:0]   ram [DEPTH];
    logic [LANES-1:0][LANE_W-1:0]   ram_rd_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (sync_reset) begin
            state_d = S_CLEAR;
        end else if (state_q == S_CLEAR && last_word) begin
            state_d = S_READY;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        clearing  = (state_q == S_CLEAR);
        init_done = (state_q == S_READY);
    end

    // ---------------- request qualification ----------------
    assign last_word = (cnt_q == AW'(DEPTH - 1));
    assign addr_ext  = 32'(mem_addr);
    assign in_range  = (addr_ext < 32'(DEPTH));
    // sync_reset wins over any request in the same cycle
    assign req_ok    = init_done && !sync_reset;
    assign rd_accept = req_ok && mem_read_en && in_range;
    assign wr_accept = req_ok && (|mem_write_en) && in_range;
    assign err_event = req_ok && (mem_read_en || (|mem_write_en)) && !in_range;

    // ---------------- control registers ----------------
    always_comb begin
        cnt_d      = cnt_q;
        addr_err_d = addr_err_q;
        rd_zero_d  = rd_zero_q;
        if (sync_reset) begin
            cnt_d      = '0;
            addr_err_d = 1'b0;
            rd_zero_d  = 1'b1;
        end else begin
            if (clearing) begin
                cnt_d = last_word ? '0 : cnt_q + AW'(1);
            end
            if (err_event) begin
                addr_err_d = 1'b1;
            end else if (err_clear) begin
                addr_err_d = 1'b0;
            end
            if (rd_accept) begin
                rd_zero_d = 1'b0;
            end else if (err_event && mem_read_en) begin
                rd_zero_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            addr_err_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            addr_err_q <= addr_err_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    assign addr_err = addr_err_q;

    // ---------------- single RAM port, shared by clear and requests ----------------
    assign ram_addr = clearing ? cnt_q : mem_addr[AW-1:0];
    assign ram_we   = clearing ? {LANES{1'b1}} : (wr_accept ? mem_write_en : '0);

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef MEM_PARITY_EN
            // even parity: stored bit makes the 9-bit lane XOR to zero
            assign ram_wdata[gi] = clearing ? '0
                : {^mem_write_data[8*gi +: 8], mem_write_data[8*gi +: 8]};
`else
            assign ram_wdata[gi] = clearing ? '0 : mem_write_data[8*gi +: 8];
`endif
            assign mem_read_data[8*gi +: 8] = rd_zero_q ? 8'h00 : ram_rd_q[gi][7:0];
        end
    endgenerate

    // Read-before-write: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (ram_we[i]) begin
                ram[ram_addr][i] <= ram_wdata[i];
            end
        end
        if (rd_accept) begin
            ram_rd_q <= ram[ram_addr];
        end
    end

`ifdef MEM_PARITY_EN
    logic             rd_check_q;
    logic             par_sticky_q, par_sticky_d;
    logic [LANES-1:0] lane_bad;
    logic             par_live;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_par
            assign lane_bad[gi] = ^ram_rd_q[gi];
        end
    endgenerate

    // Live term lets the flag rise in the same cycle the read data appears.
    assign par_live = rd_check_q && (|lane_bad);

    always_comb begin
        par_sticky_d = par_sticky_q;
        if (sync_reset) begin
            par_sticky_d = 1'b0;
        end else if (par_live) begin
            par_sticky_d = 1'b1;
        end else if (err_clear) begin
            par_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_check_q   <= 1'b0;
            par_sticky_q <= 1'b0;
        end else begin
            rd_check_q   <= rd_accept;
            par_sticky_q <= par_sticky_d;
        end
    end

    assign parity_err = par_sticky_q | par_live;
`endif

endmodule

// File: doc/reindeer_mem_responder.md
Name: reindeer_mem_responder

Overview:
- Memory-side responder for the core's unified memory port (mem_addr / mem_read_en / mem_write_en / mem_write_data / mem_read_data).
- Owns the on-chip word RAM. Services byte-lane writes and fixed 1-cycle-latency reads.
- Zero-fills the RAM after every reset before declaring itself ready. Flags out-of-range accesses.
- Sits directly below the core's memory front-end. The top level holds the core in reset until init_done is high.

Parameters:
- ADDR_BITS, 14, width of mem_addr (word address).
- XLEN, 32, data word width; byte lanes = XLEN/8.
- DEPTH, 12288, number of implemented words; must be ≤ 2**ADDR_BITS.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- sync_reset  in  1  synchronous restart of init sequence
- mem_addr  in  ADDR_BITS  word address of request
- mem_read_en  in  1  read request this cycle
- mem_write_en  in  XLEN/8  per-byte write strobes
- mem_write_data  in  XLEN  write data
- mem_read_data  out  XLEN  read data, registered
- init_done  out  1  RAM cleared, requests accepted
- addr_err  out  1  sticky: access with mem_addr ≥ DEPTH
- err_clear  in  1  clears sticky error flags

Interface: reset reset_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset values (reset_n low): mem_read_data=0, init_done=0, addr_err=0, clear counter=0, FSM=S_CLEAR.
- FSM states: S_CLEAR and S_READY.
- S_CLEAR:
  - Writes 0 to word[cnt] every cycle; cnt increments 0..DEPTH-1.
  - After the write of word DEPTH-1, go to S_READY. Clearing takes exactly DEPTH cycles.
  - init_done rises on the first cycle in S_READY (registered).
- S_CLEAR request handling:
  - All mem_* requests are ignored: no write, mem_read_data held at 0, addr_err not set.
- sync_reset (high, any state):
  - Next cycle: FSM=S_CLEAR, cnt=0, init_done=0, mem_read_data=0, addr_err=0.
  - Has priority over any request in the same cycle. A request in that cycle is dropped.
- Write (S_READY, mem_write_en≠0, mem_addr<DEPTH):
  - Byte lane i of word[mem_addr] is updated from mem_write_data[8i+7:8i] only where mem_write_en[i]=1.
  - Other lanes are unchanged.
- Read (S_READY, mem_read_en=1, mem_addr<DEPTH):
  - mem_read_data = word[mem_addr] on the next clock edge (latency 1).
  - mem_read_data holds its value until the next accepted read; no read means no change.
- Read and write in the same cycle, same address: read-before-write. mem_read_data returns the old contents; the new contents are visible on the following read.
- Out-of-range access (mem_addr ≥ DEPTH, read or any write strobe):
  - Write is dropped.
  - A read returns 0 on mem_read_data next cycle.
  - addr_err is set the next cycle and stays set until err_clear or reset.
- err_clear: clears addr_err next cycle. If an error event occurs in the same cycle, set wins and the flag stays 1.
- Reset mid-clear: the sequence restarts from word 0. Partially cleared contents are irrelevant.
- RAM inference: single synchronous port with per-byte write enables. The clear FSM muxes onto the same port; there is no second port.

Optional Feature:
- Macro: MEM_PARITY_EN.
- Defined:
  - One even-parity bit is stored per byte lane, written with each lane. S_CLEAR writes parity 0.
  - On each accepted read, stored parity is checked against the data.
  - Any mismatch sets output parity_err (1 bit, sticky, reset 0, cleared by err_clear) in the same cycle mem_read_data updates.
  - Data is still returned unmodified.
- Undefined:
  - No parity storage and no parity_err port.
  - RAM width is XLEN.

Test Plan:
- Release reset_n with DEPTH=16 → init_done=0 for 16 cycles, then 1; reading word 5 → 0x00000000.
- Write 0xDEADBEEF to addr 3 with strobe 0xF, then strobe 0x2 with data 0x0000AA00, then read addr 3 → mem_read_data=0xDEADAAEF exactly one cycle after mem_read_en.
- Same-cycle read+write at addr 7: word was 0x11111111, write 0x22222222 → read returns 0x11111111; next read returns 0x22222222.
- Access addr 16 with DEPTH=16: write 0xFFFFFFFF, then read → mem_read_data=0, addr_err=1 and sticky; pulse err_clear → addr_err=0; addr 15 unaffected.
- Write addr 2 = 0x12345678, assert sync_reset together with a write to addr 4 → init_done=0 for DEPTH cycles; afterwards addr 2 and addr 4 both read 0.
- With MEM_PARITY_EN defined: force a stored bit flip in lane 1 of addr 9, read → parity_err=1 with data returned unmodified; a read of an uncorrupted word leaves parity_err unchanged.
